mult_div_unit: RTL and testbench
================================

# mult_div_unit

Iterative multiply/divide unit for the MIPS datapath, directly downstream of the register file. It consumes the two register-file read operands (rs, rt) and executes MULT, MULTU, DIV and DIVU over multiple cycles into the architectural HI/LO registers. MTHI and MTLO also write HI/LO. The control unit uses `busy` to stall the core while an operation is in flight.

## Interface
- `WIDTH`, 32: operand and HI/LO width. The multiply product is 2*WIDTH.
- `CNT_W`, 6: iteration counter width. Must satisfy 2^CNT_W > WIDTH.

Ports (clock and reset first):
- `clk`, input, 1: the single clock. Rising-edge.
- `rst`, input, 1: reset, asynchronous and active-high.
- `start`, input, 1: launches the operation selected by `op`. Sampled only in IDLE.
- `op`, input, 2: operation select. 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- `srcA`, input, WIDTH: rs operand from register-file read port 1. Multiplicand or dividend; also the MTHI/MTLO data.
- `srcB`, input, WIDTH: rt operand from register-file read port 2. Multiplier or divisor.
- `mthi`, input, 1: write `srcA` into HI.
- `mtlo`, input, 1: write `srcA` into LO.
- `busy`, output, 1: high while the state is not IDLE.
- `done`, output, 1: one-cycle pulse when HI/LO take a new result.
- `hi`, output, WIDTH: HI register. Product upper half, or remainder.
- `lo`, output, WIDTH: LO register. Product lower half, or quotient.

## Operation
- FSM states: IDLE, CALC, FIX.
- IDLE with `start`=1:
  - Latch `op`, `srcA`, `srcB`.
  - Latch operand magnitudes. For signed ops, negative operands are two's-complement negated. |0x80000000| = 0x80000000, treated as unsigned.
  - Latch result sign. MULT: signA XOR signB. DIV quotient: signA XOR signB. DIV remainder: signA.
  - Clear the counter and go to CALC.
- CALC: one radix-2 iteration per cycle, exactly WIDTH iterations. On the last iteration (counter = WIDTH-1), go to FIX.
  - Multiply: shift-add into a 2*WIDTH accumulator.
  - Divide: restoring shift-subtract. Partial remainder is WIDTH+1 bits.
- FIX:
  - Apply sign correction.
  - Write HI/LO, set `done`=1 for one cycle, return to IDLE.
- Signed divide: quotient truncates toward zero; remainder takes the dividend's sign.
- Overflow case, 0x80000000 / 0xFFFFFFFF (DIV): LO=0x80000000, HI=0.
- Divide by zero (DIV or DIVU): LO=0xFFFFFFFF, HI=original `srcA`. Same 33-cycle latency, no exception.
- `mthi` / `mtlo` in IDLE with `start`=0: `hi` / `lo` <= `srcA` at the next edge. Both may be asserted together; both then load `srcA`. `done` is not asserted.
- Ignored inputs:
  - `start` while busy. No queueing, no effect on the operation in flight.
  - `mthi` / `mtlo` while busy.
  - `mthi` / `mtlo` when `start`=1 in the same IDLE cycle; `start` wins.
- HI/LO hold their value during CALC. They change only in FIX, on an accepted mthi/mtlo, or on reset.

## Timing
- Reset values: `hi`=0, `lo`=0, `busy`=0, `done`=0. State IDLE, counter 0.
- Reset asserted mid-operation aborts the operation immediately. HI/LO return to 0 and no `done` pulse is produced.
- Cycle numbering: E0 is the edge that samples `start`=1.
  - After E0: `busy`=1.
  - E1..E32: CALC iterations.
  - E33: FIX writes HI/LO, `done`<=1, state IDLE, `busy`<=0.
  - After E34: `done`=0.
- Latency: start-to-result is 33 cycles, for every op and operand value including divide by zero.
- Back-to-back: a new `start` may be sampled at E34, the cycle in which `done` is high.
- MTHI/MTLO latency: one edge. `hi`/`lo` are registered outputs, so no combinational path from inputs to outputs.
- The `busy`/`done` handshake with control: stall MFHI/MFLO while `busy`=1. HI/LO are valid in the cycle `done`=1.

## Test plan
- MULT, srcA=0xFFFFFFFD (-3), srcB=7 -> at E33: HI=0xFFFFFFFF, LO=0xFFFFFFEB, `done` high one cycle, `busy` high for exactly 33 cycles.
- MULTU, srcA=srcB=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001. Then MULT with the same operands -> HI=0, LO=1.
- DIV, srcA=0xFFFFFFF9 (-7), srcB=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU 7/2 -> LO=3, HI=1. DIV 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
- DIVU, srcA=0x12345678, srcB=0 -> LO=0xFFFFFFFF, HI=0x12345678 after 33 cycles.
- Start MULT 5*6, then pulse `start` with op=DIV and pulse `mthi` with srcA=0xAAAA at cycle 10 -> both ignored; final HI=0, LO=30.
- Assert `rst` at cycle 15 of a DIV -> `hi`=`lo`=0, `busy`=0 immediately, no `done`. Then `mtlo` srcA=0x55 in IDLE -> `lo`=0x55 next edge, `done` stays 0.

Source files
------------

// File: rtl/mult_div_unit.sv
// Iterative MIPS multiply/divide unit: radix-2 shift-add multiply and restoring divide
// into the architectural HI/LO registers, plus MTHI/MTLO writes while idle.
module mult_div_unit #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] srcA,
    input  logic [WIDTH-1:0] srcB,
    input  logic             mthi,
    input  logic             mtlo,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned W1 = WIDTH + 1;
    localparam int unsigned W2 = WIDTH + 2;
    localparam int unsigned WP = 2 * WIDTH;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2
    } state_e;

    state_e            r_state, w_state_nxt;
    logic              r_is_div, w_is_div_nxt;
    logic              r_b_zero, w_b_zero_nxt;
    logic              r_neg_q, w_neg_q_nxt;
    logic              r_neg_r, w_neg_r_nxt;
    logic [WIDTH-1:0]  r_a, w_a_nxt;
    logic [WIDTH-1:0]  r_mag_a, w_mag_a_nxt;
    logic [WIDTH-1:0]  r_mag_b, w_mag_b_nxt;
    logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
    logic [WP-1:0]     r_acc, w_acc_nxt;
    logic [W1-1:0]     r_rem, w_rem_nxt;
    logic              r_busy, w_busy_nxt;
    logic              r_done, w_done_nxt;
    logic [WIDTH-1:0]  r_hi, w_hi_nxt;
    logic [WIDTH-1:0]  r_lo, w_lo_nxt;

    // Operand magnitudes; MULTU/DIVU (op[0]=1) treat both operands as unsigned
    logic              w_sign_a, w_sign_b;
    logic [WIDTH-1:0]  w_in_mag_a, w_in_mag_b;
    assign w_sign_a   = ~op[0] & srcA[WIDTH-1];
    assign w_sign_b   = ~op[0] & srcB[WIDTH-1];
    assign w_in_mag_a = w_sign_a ? -srcA : srcA;
    assign w_in_mag_b = w_sign_b ? -srcB : srcB;

    // Multiply step: conditionally add multiplicand into the upper half, then shift right
    logic [W1-1:0]     w_madd;
    assign w_madd = {1'b0, r_acc[WP-1:WIDTH]} + {1'b0, (r_acc[0] ? r_mag_a : WIDTH'(0))};

    // Divide step: shift next dividend bit into the partial remainder and trial-subtract
    logic [W2-1:0]     w_trial, w_diff;
    logic              w_ge;
    assign w_trial = {r_rem, r_acc[WIDTH-1]};
    assign w_diff  = w_trial - W2'(r_mag_b);
    assign w_ge    = (w_trial >= W2'(r_mag_b));

    logic [WP-1:0]     w_prod;
    logic [WIDTH-1:0]  w_quo, w_rmd;
    assign w_prod = r_neg_q ? -r_acc : r_acc;
    assign w_quo  = r_neg_q ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
    assign w_rmd  = r_neg_r ? -r_rem[WIDTH-1:0] : r_rem[WIDTH-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_nxt = S_CALC;
            S_CALC:  if (r_cnt == LAST_CNT) w_state_nxt = S_FIX;
            S_FIX:   w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_is_div_nxt = r_is_div;
        w_b_zero_nxt = r_b_zero;
        w_neg_q_nxt  = r_neg_q;
        w_neg_r_nxt  = r_neg_r;
        w_a_nxt      = r_a;
        w_mag_a_nxt  = r_mag_a;
        w_mag_b_nxt  = r_mag_b;
        w_cnt_nxt    = r_cnt;
        w_acc_nxt    = r_acc;
        w_rem_nxt    = r_rem;
        w_hi_nxt     = r_hi;
        w_lo_nxt     = r_lo;
        w_done_nxt   = 1'b0;
        w_busy_nxt   = (w_state_nxt != S_IDLE);
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_is_div_nxt = op[1];
                    w_b_zero_nxt = (srcB == '0);
                    w_neg_q_nxt  = w_sign_a ^ w_sign_b;
                    w_neg_r_nxt  = w_sign_a;
                    w_a_nxt      = srcA;
                    w_mag_a_nxt  = w_in_mag_a;
                    w_mag_b_nxt  = w_in_mag_b;
                    w_cnt_nxt    = '0;
                    w_rem_nxt    = '0;
                    w_acc_nxt    = op[1] ? {WIDTH'(0), w_in_mag_a} : {WIDTH'(0), w_in_mag_b};
                end else begin
                    if (mthi) w_hi_nxt = srcA;
                    if (mtlo) w_lo_nxt = srcA;
                end
            end
            S_CALC: begin
                w_cnt_nxt = r_cnt + CNT_W'(1);
                if (r_is_div) begin
                    w_rem_nxt = W1'(w_ge ? w_diff : w_trial);
                    w_acc_nxt = {r_acc[WP-1:WIDTH], r_acc[WIDTH-2:0], w_ge};
                end else begin
                    w_acc_nxt = {w_madd, r_acc[WIDTH-1:1]};
                end
            end
            S_FIX: begin
                w_done_nxt = 1'b1;
                if (!r_is_div) begin
                    w_hi_nxt = w_prod[WP-1:WIDTH];
                    w_lo_nxt = w_prod[WIDTH-1:0];
                end else if (r_b_zero) begin
                    w_hi_nxt = r_a;
                    w_lo_nxt = '1;
                end else begin
                    w_hi_nxt = w_rmd;
                    w_lo_nxt = w_quo;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_is_div <= 1'b0;
            r_b_zero <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_a      <= '0;
            r_mag_a  <= '0;
            r_mag_b  <= '0;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_rem    <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
        end else begin
            r_is_div <= w_is_div_nxt;
            r_b_zero <= w_b_zero_nxt;
            r_neg_q  <= w_neg_q_nxt;
            r_neg_r  <= w_neg_r_nxt;
            r_a      <= w_a_nxt;
            r_mag_a  <= w_mag_a_nxt;
            r_mag_b  <= w_mag_b_nxt;
            r_cnt    <= w_cnt_nxt;
            r_acc    <= w_acc_nxt;
            r_rem    <= w_rem_nxt;
            r_busy   <= w_busy_nxt;
            r_done   <= w_done_nxt;
            r_hi     <= w_hi_nxt;
            r_lo     <= w_lo_nxt;
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed cases plus random ops against
// an arithmetic reference model of MIPS MULT/MULTU/DIV/DIVU semantics.
module tb_mult_div_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] srcA, srcB;
    logic        mthi, mtlo;
    logic        busy, done;
    logic [31:0] hi, lo;

    int n_chk = 0;
    int n_err = 0;

    mult_div_unit #(.WIDTH(32), .CNT_W(6)) dut (
        .clk  (clk),
        .rst  (rst),
        .start(start),
        .op   (op),
        .srcA (srcA),
        .srcB (srcB),
        .mthi (mthi),
        .mtlo (mtlo),
        .busy (busy),
        .done (done),
        .hi   (hi),
        .lo   (lo)
    );

    always #5 clk = ~clk;

    // Reference: returns {hi, lo} using plain 64-bit / signed integer arithmetic
    function automatic logic [63:0] ref_model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        longint      p;
        logic [63:0] u;
        int          sa, sb, q, r;
        case (o)
            2'd0: begin
                p = longint'($signed(a)) * longint'($signed(b));
                return 64'(p);
            end
            2'd1: begin
                u = {32'd0, a} * {32'd0, b};
                return u;
            end
            2'd2: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
                sa = a; sb = b;
                q = sa / sb;
                r = sa % sb;
                return {32'(r), 32'(q)};
            end
            default: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                return {a % b, a / b};
            end
        endcase
    endfunction

    // Launch an op at the next edge and wait (bounded) for done; lat=-1 on timeout
    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          output int lat, output bit busy_ok);
        start = 1'b1; op = o; srcA = a; srcB = b;
        @(posedge clk); #1;
        start = 1'b0;
        busy_ok = (busy === 1'b1);
        lat = -1;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk); #1;
            if (done === 1'b1) begin
                lat = n;
                if (busy !== 1'b0) busy_ok = 1'b0;
                break;
            end
            if (busy !== 1'b1) busy_ok = 1'b0;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b0; op = 2'd0; srcA = '0; srcB = '0; mthi = 1'b0; mtlo = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_chk++;
        if ({busy, done, hi, lo} !== 66'd0) begin
            n_err++;
            $display("FAIL reset busy=%b done=%b hi=%h lo=%h required all zero", busy, done, hi, lo);
        end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_directed;
        logic [1:0]  ops [7] = '{2'd0, 2'd1, 2'd0, 2'd2, 2'd3, 2'd2, 2'd3};
        logic [31:0] as  [7] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'd7, 32'h8000_0000, 32'h1234_5678};
        logic [31:0] bs  [7] = '{32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd2, 32'd2, 32'hFFFF_FFFF, 32'd0};
        logic [31:0] ehi [7] = '{32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'd0, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'h1234_5678};
        logic [31:0] elo [7] = '{32'hFFFF_FFEB, 32'd1, 32'd1, 32'hFFFF_FFFD, 32'd3, 32'h8000_0000, 32'hFFFF_FFFF};
        int lat;
        bit bok;
        for (int i = 0; i < 7; i++) begin
            run_op(ops[i], as[i], bs[i], lat, bok);
            n_chk++;
            if (lat != 33 || !bok) begin
                n_err++;
                $display("FAIL directed%0d_latency lat=%0d busy_ok=%0d required lat=33 busy_ok=1", i, lat, bok);
            end
            n_chk++;
            if (hi !== ehi[i] || lo !== elo[i]) begin
                n_err++;
                $display("FAIL directed%0d_result hi=%h lo=%h required hi=%h lo=%h", i, hi, lo, ehi[i], elo[i]);
            end
            @(posedge clk); #1;
            n_chk++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                n_err++;
                $display("FAIL directed%0d_done_pulse done=%b busy=%b required 0 0", i, done, busy);
            end
        end
    endtask

    task automatic test_ignore;
        logic [31:0] hi0;
        int lat;
        hi0 = hi;
        start = 1'b1; op = 2'd0; srcA = 32'd5; srcB = 32'd6;
        @(posedge clk); #1;
        start = 1'b0;
        lat = -1;
        for (int n = 1; n <= 40; n++) begin
            if (n == 10) begin start = 1'b1; op = 2'd2; mthi = 1'b1; srcA = 32'hAAAA; end
            @(posedge clk); #1;
            if (n == 10) begin
                start = 1'b0; mthi = 1'b0;
                n_chk++;
                if (hi !== hi0) begin
                    n_err++;
                    $display("FAIL ignore_mthi_busy hi=%h required %h", hi, hi0);
                end
            end
            if (done === 1'b1) begin lat = n; break; end
        end
        n_chk++;
        if (lat != 33 || hi !== 32'd0 || lo !== 32'd30) begin
            n_err++;
            $display("FAIL ignore_result lat=%0d hi=%h lo=%h required 33 0 1e", lat, hi, lo);
        end
        @(posedge clk); #1;
        n_chk++;
        if (busy !== 1'b0) begin
            n_err++;
            $display("FAIL ignore_no_queue busy=%b required 0", busy);
        end
    endtask

    task automatic test_mt;
        int lat;
        bit bok;
        mthi = 1'b1; mtlo = 1'b1; srcA = 32'hCAFE_0001;
        @(posedge clk); #1;
        mthi = 1'b0; mtlo = 1'b0;
        n_chk++;
        if (hi !== 32'hCAFE_0001 || lo !== 32'hCAFE_0001 || done !== 1'b0) begin
            n_err++;
            $display("FAIL mt_both hi=%h lo=%h done=%b required cafe0001 cafe0001 0", hi, lo, done);
        end
        mthi = 1'b1; srcA = 32'h0BAD_F00D;
        @(posedge clk); #1;
        mthi = 1'b0;
        n_chk++;
        if (hi !== 32'h0BAD_F00D || lo !== 32'hCAFE_0001) begin
            n_err++;
            $display("FAIL mt_hi_only hi=%h lo=%h required 0badf00d cafe0001", hi, lo);
        end
        // start wins over mtlo in the same idle cycle
        mtlo = 1'b1; start = 1'b1; op = 2'd3; srcA = 32'd100; srcB = 32'd9;
        @(posedge clk); #1;
        mtlo = 1'b0; start = 1'b0;
        n_chk++;
        if (lo !== 32'hCAFE_0001 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL mt_start_wins lo=%h busy=%b required cafe0001 1", lo, busy);
        end
        lat = -1;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk); #1;
            if (done === 1'b1) begin lat = n; break; end
        end
        n_chk++;
        if (lat != 33 || hi !== 32'd1 || lo !== 32'd11) begin
            n_err++;
            $display("FAIL mt_start_result lat=%0d hi=%h lo=%h required 33 1 b", lat, hi, lo);
        end
        bok = 1'b1;
        if (!bok) n_err++;
    endtask

    task automatic test_reset_mid;
        bit saw_done;
        mthi = 1'b1; srcA = 32'h1234;
        @(posedge clk); #1;
        mthi = 1'b0;
        start = 1'b1; op = 2'd2; srcA = 32'd100; srcB = 32'd7;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (15) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        n_chk++;
        if (hi !== 32'd0 || lo !== 32'd0 || busy !== 1'b0 || done !== 1'b0) begin
            n_err++;
            $display("FAIL reset_mid hi=%h lo=%h busy=%b done=%b required 0 0 0 0", hi, lo, busy, done);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        saw_done = 1'b0;
        repeat (25) begin
            @(posedge clk); #1;
            if (done !== 1'b0 || busy !== 1'b0) saw_done = 1'b1;
        end
        n_chk++;
        if (saw_done) begin
            n_err++;
            $display("FAIL reset_mid_quiet done/busy rose after abort, required both 0");
        end
        mtlo = 1'b1; srcA = 32'h55;
        @(posedge clk); #1;
        mtlo = 1'b0;
        n_chk++;
        if (lo !== 32'h55 || hi !== 32'd0 || done !== 1'b0) begin
            n_err++;
            $display("FAIL reset_mid_mtlo lo=%h hi=%h done=%b required 55 0 0", lo, hi, done);
        end
    endtask

    task automatic test_back_to_back;
        logic [63:0] exp;
        int lat;
        bit bok;
        // second start is presented in the cycle done is high (sampled at E34)
        run_op(2'd1, 32'd1000, 32'd3000, lat, bok);
        run_op(2'd2, 32'hFFFF_FF00, 32'd16, lat, bok);
        exp = ref_model(2'd2, 32'hFFFF_FF00, 32'd16);
        n_chk++;
        if (lat != 33 || !bok || {hi, lo} !== exp) begin
            n_err++;
            $display("FAIL back_to_back lat=%0d busy_ok=%0d hi_lo=%h required 33 1 %h", lat, bok, {hi, lo}, exp);
        end
    endtask

    task automatic test_random;
        logic [1:0]  o;
        logic [31:0] a, b;
        logic [63:0] exp;
        int lat;
        bit bok;
        for (int i = 0; i < 24; i++) begin
            o = 2'($urandom_range(0, 3));
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 5))
                0: b = 32'd0;
                1: b = 32'($urandom_range(1, 17));
                2: a = 32'h8000_0000;
                3: b = 32'hFFFF_FFFF;
                default: ;
            endcase
            exp = ref_model(o, a, b);
            run_op(o, a, b, lat, bok);
            n_chk++;
            if (lat != 33 || !bok || {hi, lo} !== exp) begin
                n_err++;
                $display("FAIL random%0d op=%0d a=%h b=%h lat=%0d busy_ok=%0d hi_lo=%h required %h",
                         i, o, a, b, lat, bok, {hi, lo}, exp);
            end
        end
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset;
        test_directed;
        test_ignore;
        test_mt;
        test_reset_mid;
        test_back_to_back;
        test_random;
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
